// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the REDUX-V instruction sequencer: state encodings,
// control_unit signal bit indices and opcodes.
package instr_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  // Bit positions inside the control_unit signals vector.
  localparam int SIG_BR = 0;
  localparam int SIG_J  = 1;
  localparam int SIG_RE = 2;
  localparam int SIG_WE = 3;
  localparam int SIG_DM = 4;
  localparam int SIG_SP = 5;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_LD   = 4'h1;
  localparam logic [OP_W-1:0] OP_ST   = 4'h2;
  localparam logic [OP_W-1:0] OP_BRZR = 4'h3;
  localparam logic [OP_W-1:0] OP_JI   = 4'h4;
  localparam logic [OP_W-1:0] OP_PUSH = 4'h5;
  localparam logic [OP_W-1:0] OP_POP  = 4'h6;

endpackage

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the REDUX-V datapath;
// owns the shared memory port and turns latched control signals into strobes.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int OP    = 4,
  parameter int SIG_W = 10,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [OP-1:0]        op,
  input  logic [SIG_W-1:0]     signals,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic                 ir_we,
  output logic                 reg_we,
  output logic                 sp_we,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic [STATE_W-1:0]   state,
  output logic                 busy,
  output logic [CNT_W-1:0]     retired
);

  state_e           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // The opcode is decoded by control_unit; only its signals vector matters here.
  logic unused_inputs;
  assign unused_inputs = ^op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sig_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    retired_d = retired_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    sp_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        sig_d   = signals;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = (sig_q[SIG_DM] || sig_q[SIG_WE]) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // Request stays asserted and unchanged for the whole wait.
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = sig_q[SIG_WE];
        if (mem_ready) state_d = S_WB;
      end
      S_WB: begin
        reg_we    = sig_q[SIG_RE];
        sp_we     = sig_q[SIG_SP];
        pc_we     = 1'b1;
        pc_sel    = sig_q[SIG_J] | (sig_q[SIG_BR] & zero);
        retired_d = retired_q + CNT_W'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state   = state_q;
  assign busy    = (state_q != S_IDLE);
  assign retired = retired_q;

`ifndef SYNTHESIS
  a_strobe_excl: assert property (@(posedge clk) disable iff (rst)
    (state_q != S_WB) |-> $onehot0({ir_we, reg_we, pc_we}));

  a_mem_hold: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_MEM && !mem_ready) |=> (state_q == S_MEM && mem_req && addr_sel));
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized self-checking bench for instr_sequencer: each instruction is
// expanded into its expected per-cycle output trace and compared every cycle.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  localparam int OPW = 4;
  localparam int SW  = 10;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst, run, zero, mem_ready;
  logic [OPW-1:0] op;
  logic [SW-1:0]  signals;
  logic           mem_req, mem_we, addr_sel, ir_we, reg_we, sp_we, pc_we, pc_sel, busy;
  logic [2:0]     state;
  logic [CW-1:0]  retired;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] exp_ret;

  instr_sequencer #(.OP(OPW), .SIG_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .signals(signals), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .reg_we(reg_we), .sp_we(sp_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .state(state), .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  wire [11:0] obs = {state, busy, mem_req, mem_we, addr_sel, ir_we, reg_we, sp_we, pc_we, pc_sel};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mk(input logic [2:0] st, input logic mreq, input logic mwe,
                                     input logic asel, input logic irwe, input logic rwe,
                                     input logic spwe, input logic pcwe, input logic pcsel);
    return {st, st != 3'd0, mreq, mwe, asel, irwe, rwe, spwe, pcwe, pcsel};
  endfunction

  // Inputs are set at posedge+1; outputs are checked 4ns later, before the next edge.
  task automatic cycle_chk(input string tag, input logic [11:0] exp);
    #4;
    check_eq(tag, {20'd0, obs}, {20'd0, exp});
    check_eq({tag, "_ret"}, {16'd0, retired}, {16'd0, exp_ret});
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    signals   = SW'($urandom);
    op        = OPW'($urandom);
    zero      = 1'($urandom);
    mem_ready = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n, input logic go);
    for (int i = 0; i < n; i++) begin
      noise();
      run = 1'b0;
      cycle_chk("idle", mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    if (go) begin
      noise();
      run = 1'b1;
      cycle_chk("idle_go", mk(S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // zwb: 0/1 forces the zero flag during WB, 2 leaves it random.
  task automatic exec_instr(input string nm, input logic [SW-1:0] sig, input int fw,
                            input int mw, input logic run_after, input int zwb);
    logic is_mem;
    is_mem = sig[SIG_DM] | sig[SIG_WE];
    for (int i = 0; i <= fw; i++) begin
      noise();
      run       = 1'($urandom);
      mem_ready = (i == fw);
      cycle_chk({nm, "_fetch"}, mk(S_FETCH, 1, 0, 0, i == fw, 0, 0, 0, 0));
    end
    noise();
    signals = sig;
    cycle_chk({nm, "_decode"}, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
    noise();
    run = 1'($urandom);
    cycle_chk({nm, "_exec"}, mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 0));
    if (is_mem) begin
      for (int j = 0; j <= mw; j++) begin
        noise();
        run       = 1'($urandom);
        mem_ready = (j == mw);
        cycle_chk({nm, "_mem"}, mk(S_MEM, 1, sig[SIG_WE], 1, 0, 0, 0, 0, 0));
      end
    end
    noise();
    run = run_after;
    if (zwb != 2) zero = zwb[0];
    cycle_chk({nm, "_wb"}, mk(S_WB, 0, 0, 0, 0, sig[SIG_RE], sig[SIG_SP], 1,
                             sig[SIG_J] | (sig[SIG_BR] & zero)));
    exp_ret++;
  endtask

  localparam logic [SW-1:0] SG_ADD  = SW'(1 << SIG_RE);
  localparam logic [SW-1:0] SG_LD   = SW'((1 << SIG_DM) | (1 << SIG_RE));
  localparam logic [SW-1:0] SG_ST   = SW'(1 << SIG_WE);
  localparam logic [SW-1:0] SG_BRZR = SW'(1 << SIG_BR);
  localparam logic [SW-1:0] SG_JI   = SW'(1 << SIG_J);
  localparam logic [SW-1:0] SG_PUSH = SW'((1 << SIG_WE) | (1 << SIG_SP) | (1 << SIG_RE));
  localparam logic [SW-1:0] SG_POP  = SW'((1 << SIG_DM) | (1 << SIG_SP) | (1 << SIG_RE));

  initial begin
    rst = 1'b1; run = 1'b0; zero = 1'b0; mem_ready = 1'b0; op = OP_ADD; signals = '0;
    exp_ret = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state, then stay idle
    idle_cycles(5, 1'b1);

    // Directed instruction classes
    op = OP_ADD;
    exec_instr("add", SG_ADD, 0, 0, 1'b1, 2);
    exec_instr("st_wait", SG_ST, 0, 3, 1'b1, 2);
    exec_instr("brzr_z1", SG_BRZR, 0, 0, 1'b1, 1);
    exec_instr("brzr_z0", SG_BRZR, 0, 0, 1'b1, 0);
    exec_instr("ji", SG_JI, 1, 0, 1'b1, 0);
    exec_instr("push", SG_PUSH, 0, 0, 1'b1, 2);
    exec_instr("pop", SG_POP, 0, 1, 1'b1, 2);
    exec_instr("ld", SG_LD, 2, 2, 1'b0, 2);
    idle_cycles(3, 1'b1);

    // Random instruction stream with random waits and run drops
    for (int k = 0; k < 80; k++) begin
      logic ra;
      ra = ($urandom_range(0, 3) != 0);
      exec_instr("rnd", SW'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), ra, 2);
      if (!ra) idle_cycles($urandom_range(0, 3), 1'b1);
    end

    // Reset during a MEM wait of a store abandons the access
    exec_instr("pre_rst", SG_ADD, 0, 0, 1'b1, 2);
    noise(); run = 1'b1; mem_ready = 1'b1;
    cycle_chk("rst_fetch", mk(S_FETCH, 1, 0, 0, 1, 0, 0, 0, 0));
    noise(); signals = SG_ST;
    cycle_chk("rst_decode", mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 0));
    noise();
    cycle_chk("rst_exec", mk(S_EXEC, 0, 0, 0, 0, 0, 0, 0, 0));
    noise(); mem_ready = 1'b0;
    cycle_chk("rst_memwait", mk(S_MEM, 1, 1, 1, 0, 0, 0, 0, 0));
    noise(); mem_ready = 1'b0; rst = 1'b1;
    cycle_chk("rst_memhold", mk(S_MEM, 1, 1, 1, 0, 0, 0, 0, 0));
    rst = 1'b0;
    exp_ret = '0;
    idle_cycles(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
